// File: rtl/multi_chan_count_src.sv
// multi_chan_count_src: N_CH independent counters, each with its own mode, feed
// per-channel FIFOs. A round-robin arbiter drains the FIFOs into one registered
// valid/ready output stream. Each beat is tagged with its source channel and
// carries a flag saying whether the value came from a wrap transition.
module multi_chan_count_src #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 2,
  parameter int DEPTH = 4,
  parameter int STEP  = 1,
  parameter int LIMIT = (2 ** WIDTH) - 1,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   en,
  input  logic [2*N_CH-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_wrap
);

  localparam int AW = $clog2(DEPTH);

  // ext_t doubles as the FIFO entry format {wrap, data}
  typedef logic [WIDTH:0]   ext_t;
  typedef logic [WIDTH-1:0] data_t;
  typedef logic [AW-1:0]    ptr_t;
  typedef logic [AW:0]      fill_t;
  typedef logic [CW-1:0]    ch_t;

  localparam ext_t  STEP_X    = ext_t'(STEP);
  localparam ext_t  LIMIT_X   = ext_t'(LIMIT);
  localparam ext_t  ONE_X     = ext_t'(1);
  localparam ext_t  ZERO_X    = ext_t'(0);
  localparam data_t DATA_ZERO = data_t'(0);
  localparam ptr_t  PTR_ZERO  = ptr_t'(0);
  localparam ptr_t  PTR_ONE   = ptr_t'(1);
  localparam fill_t FILL_ZERO = fill_t'(0);
  localparam fill_t FILL_ONE  = fill_t'(1);
  localparam fill_t FILL_FULL = fill_t'(DEPTH);
  localparam ch_t   CH_ZERO   = ch_t'(0);
  localparam ch_t   CH_ONE    = ch_t'(1);
  localparam ch_t   CH_LAST   = ch_t'(N_CH - 1);

  // Advance one counter. The extra bit keeps cur+STEP and cur+LIMIT+1 from
  // overflowing when LIMIT is the full WIDTH range. Returns {wrap, next_value}.
  function automatic ext_t next_cnt(input data_t cur, input logic [1:0] m);
    ext_t cur_x;
    ext_t sum_x;
    ext_t res_x;
    logic wrap;
    cur_x = {1'b0, cur};
    sum_x = cur_x + STEP_X;
    res_x = cur_x;
    wrap  = 1'b0;
    case (m)
      2'b00: begin
        if (sum_x > LIMIT_X) begin
          res_x = sum_x - LIMIT_X - ONE_X;
          wrap  = 1'b1;
        end else begin
          res_x = sum_x;
          wrap  = 1'b0;
        end
      end
      2'b01: begin
        if (cur_x < STEP_X) begin
          res_x = cur_x + LIMIT_X + ONE_X - STEP_X;
          wrap  = 1'b1;
        end else begin
          res_x = cur_x - STEP_X;
          wrap  = 1'b0;
        end
      end
      2'b10: begin
        res_x = (sum_x > LIMIT_X) ? LIMIT_X : sum_x;
        wrap  = 1'b0;
      end
      2'b11: begin
        res_x = cur_x;
        wrap  = 1'b0;
      end
      default: begin
        res_x = cur_x;
        wrap  = 1'b0;
      end
    endcase
    return {wrap, res_x[WIDTH-1:0]};
  endfunction

  // First non-empty channel at or after 'start', modulo N_CH. Returns {found, channel}.
  function automatic logic [CW:0] find_grant(input ch_t start, input logic [N_CH-1:0] ne);
    logic found;
    ch_t  gnt;
    int   idx;
    found = 1'b0;
    gnt   = CH_ZERO;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(start) + k) % N_CH;
      if (!found && ne[idx]) begin
        found = 1'b1;
        gnt   = ch_t'(idx);
      end
    end
    return {found, gnt};
  endfunction

  data_t cnt_q   [N_CH];
  data_t cnt_d   [N_CH];
  logic  wrapf_q [N_CH];
  logic  wrapf_d [N_CH];
  ext_t  mem_q   [N_CH][DEPTH];
  ext_t  mem_d   [N_CH][DEPTH];
  ptr_t  wptr_q  [N_CH];
  ptr_t  wptr_d  [N_CH];
  ptr_t  rptr_q  [N_CH];
  ptr_t  rptr_d  [N_CH];
  fill_t fill_q  [N_CH];
  fill_t fill_d  [N_CH];
  ch_t   rr_q, rr_d;

  logic  out_valid_q, out_valid_d;
  data_t out_data_q, out_data_d;
  ch_t   out_ch_q, out_ch_d;
  logic  out_wrap_q, out_wrap_d;

  logic            load_s;
  logic [N_CH-1:0] ne_s;
  logic [N_CH-1:0] push_s;
  logic [N_CH-1:0] pop_s;
  logic            grant_found_s;
  ch_t             grant_s;
  ext_t            head_s;

  // Push/pop decisions from registered fill levels, round-robin grant and head-of-FIFO mux
  always_comb begin
    load_s = !out_valid_q || out_ready;
    for (int c = 0; c < N_CH; c++) begin
      ne_s[c]   = (fill_q[c] != FILL_ZERO);
      push_s[c] = en[c] && (fill_q[c] != FILL_FULL);
    end
    {grant_found_s, grant_s} = find_grant(rr_q, ne_s);
    head_s = ZERO_X;
    for (int c = 0; c < N_CH; c++) begin
      pop_s[c] = load_s && grant_found_s && (grant_s == ch_t'(c));
      head_s   = head_s | ({(WIDTH+1){pop_s[c]}} & mem_q[c][rptr_q[c]]);
    end
  end

  // Next state of counters, wrap flags and FIFO storage/pointers/fill levels
  always_comb begin
    cnt_d   = cnt_q;
    wrapf_d = wrapf_q;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    for (int c = 0; c < N_CH; c++) begin
      if (push_s[c]) begin
        mem_d[c][wptr_q[c]]      = {wrapf_q[c], cnt_q[c]};
        wptr_d[c]                = wptr_q[c] + PTR_ONE;
        {wrapf_d[c], cnt_d[c]}   = next_cnt(cnt_q[c], mode[2*c +: 2]);
      end else begin
        wptr_d[c] = wptr_q[c];
      end
      if (pop_s[c]) begin
        rptr_d[c] = rptr_q[c] + PTR_ONE;
      end else begin
        rptr_d[c] = rptr_q[c];
      end
      case ({push_s[c], pop_s[c]})
        2'b10:   fill_d[c] = fill_q[c] + FILL_ONE;
        2'b01:   fill_d[c] = fill_q[c] - FILL_ONE;
        default: fill_d[c] = fill_q[c];
      endcase
    end
  end

  // Output register: reloads whenever empty or accepted, holds while stalled
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_wrap_d  = out_wrap_q;
    rr_d        = rr_q;
    if (load_s) begin
      if (grant_found_s) begin
        out_valid_d = 1'b1;
        out_data_d  = head_s[WIDTH-1:0];
        out_wrap_d  = head_s[WIDTH];
        out_ch_d    = grant_s;
        rr_d        = (grant_s == CH_LAST) ? CH_ZERO : grant_s + CH_ONE;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset that discards all queued and presented data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]   <= DATA_ZERO;
        wrapf_q[c] <= 1'b0;
        wptr_q[c]  <= PTR_ZERO;
        rptr_q[c]  <= PTR_ZERO;
        fill_q[c]  <= FILL_ZERO;
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[c][k] <= ZERO_X;
        end
      end
      rr_q        <= CH_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= DATA_ZERO;
      out_ch_q    <= CH_ZERO;
      out_wrap_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wrapf_q     <= wrapf_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fill_q      <= fill_d;
      mem_q       <= mem_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_wrap_q  <= out_wrap_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_wrap  = out_wrap_q;

endmodule
